// File: rtl/ref_row_packer_pkg.sv
// Shared motion-estimation definitions for the reference row packer: pixel and row
// geometry, the packer state encoding and the lane index type.
package ref_row_packer_pkg;

    localparam int PIX_W   = 8;
    localparam int ROW_PIX = 23;
    localparam int ROW_W   = ROW_PIX * PIX_W;
    localparam int IN_W    = 8 * PIX_W;
    localparam int LANES   = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef logic [1:0] lane_t;

endpackage

// File: rtl/ref_row_packer_if.sv
// Handshake and row bus of the reference row packer. err_o exists only when
// REF_PACK_ERR_EN is defined.
interface ref_row_packer_if;
    import ref_row_packer_pkg::*;

    logic             start_i;
    logic [IN_W-1:0]  in_data_i;
    logic             in_valid_i;
    logic             in_ready_o;
    logic [ROW_W-1:0] row_o;
    logic             row_valid_o;
    logic             busy_o;
    logic             done_o;
`ifdef REF_PACK_ERR_EN
    logic             err_o;
`endif

    modport master (
`ifdef REF_PACK_ERR_EN
        input  err_o,
`endif
        output start_i, in_data_i, in_valid_i,
        input  in_ready_o, row_o, row_valid_o, busy_o, done_o
    );

    modport slave (
`ifdef REF_PACK_ERR_EN
        output err_o,
`endif
        input  start_i, in_data_i, in_valid_i,
        output in_ready_o, row_o, row_valid_o, busy_o, done_o
    );

endinterface

// File: rtl/ref_row_lane_mux.sv
// Decodes the word counter into one write enable per assembly-register lane.
module ref_row_lane_mux
    import ref_row_packer_pkg::*;
(
    input  lane_t            wcnt,
    input  logic             wr_en,
    output logic [LANES-1:0] lane_we
);

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign lane_we[gi] = wr_en && (wcnt == lane_t'(gi));
        end
    endgenerate

endmodule

// File: rtl/ref_row_packer.sv
// Packs three 64-bit reference words into one 23-pixel search-window row, ROWS rows
// per window. Optional sticky protocol error flag under REF_PACK_ERR_EN.
module ref_row_packer
    import ref_row_packer_pkg::*;
#(
    parameter int ROWS = 23
) (
    input  logic              clk_i,
    input  logic              rst_i,
    ref_row_packer_if.slave   bus
);

    localparam int RCW = (ROWS > 1) ? $clog2(ROWS) : 1;

    state_t           state_reg, state_next;
    lane_t            wcnt_reg, wcnt_next;
    logic [RCW-1:0]   rcnt_reg, rcnt_next;
    logic [ROW_W-1:0] row_reg;
    logic             row_valid_reg;
    logic             done_reg;
    logic [LANES-1:0] lane_we;
    logic             xfer;
    logic             row_done;

    assign xfer     = bus.in_valid_i && (state_reg == FILL);
    assign row_done = lane_we[LANES-1];

    ref_row_lane_mux u_lane_mux (
        .wcnt    (wcnt_reg),
        .wr_en   (xfer),
        .lane_we (lane_we)
    );

    // The last lane is never stored: it is taken straight from the input word.
    genvar gi;
    generate
        for (gi = 0; gi < LANES - 1; gi++) begin : g_asm
            logic [IN_W-1:0] lane_reg;
            always_ff @(posedge clk_i) begin
                if (!rst_i) begin
                    lane_reg <= '0;
                end else if (lane_we[gi]) begin
                    lane_reg <= bus.in_data_i;
                end
            end
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        wcnt_next  = wcnt_reg;
        rcnt_next  = rcnt_reg;
        case (state_reg)
            IDLE: begin
                if (bus.start_i) begin
                    state_next = FILL;
                    wcnt_next  = '0;
                    rcnt_next  = '0;
                end
            end
            FILL: begin
                if (xfer) begin
                    if (row_done) begin
                        wcnt_next = '0;
                        if (rcnt_reg == RCW'(ROWS - 1)) begin
                            state_next = DONE;
                        end else begin
                            rcnt_next = rcnt_reg + 1'b1;
                        end
                    end else begin
                        wcnt_next = wcnt_reg + 1'b1;
                    end
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // done_o trails the DONE state by one cycle so it never coincides with the last row.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_reg     <= IDLE;
            wcnt_reg      <= '0;
            rcnt_reg      <= '0;
            row_reg       <= '0;
            row_valid_reg <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            wcnt_reg      <= wcnt_next;
            rcnt_reg      <= rcnt_next;
            row_valid_reg <= row_done;
            done_reg      <= (state_reg == DONE);
            if (row_done) begin
                row_reg <= {bus.in_data_i[ROW_W-2*IN_W-1:0], g_asm[1].lane_reg, g_asm[0].lane_reg};
            end
        end
    end

`ifdef REF_PACK_ERR_EN
    logic err_reg;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            err_reg <= 1'b0;
        end else if ((bus.start_i && state_reg != IDLE) ||
                     (bus.in_valid_i && state_reg != FILL)) begin
            err_reg <= 1'b1;
        end
    end

    assign bus.err_o = err_reg;
`endif

    assign bus.in_ready_o  = (state_reg == FILL);
    assign bus.busy_o      = (state_reg != IDLE);
    assign bus.row_o       = row_reg;
    assign bus.row_valid_o = row_valid_reg;
    assign bus.done_o      = done_reg;

endmodule

// File: tb/tb_ref_row_packer.sv
// Scoreboard bench for ref_row_packer: expected rows are queued as words are accepted
// and compared as row_valid_o pulses arrive.
module tb_ref_row_packer;
    import ref_row_packer_pkg::*;

    localparam int ROWS = 23;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   total_cnt = 0;
    int   bad_cnt = 0;

    logic [ROW_W-1:0] exp_q[$];
    logic [ROW_W-1:0] exp_mon;
    int   rows_in_window = 0;
    int   last_rv_cyc = 0;
    bit   spacing_on = 1'b0;

    ref_row_packer_if bus ();

    ref_row_packer #(.ROWS(ROWS)) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [ROW_W-1:0] got, input logic [ROW_W-1:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [IN_W-1:0] make_word(input int w);
        logic [IN_W-1:0] word;
        for (int b = 0; b < 8; b++) word[8*b +: 8] = 8'(8 * w + b);
        return word;
    endfunction

    function automatic logic [ROW_W-1:0] make_row(input int base, input int r);
        logic [ROW_W-1:0] row;
        for (int k = 0; k < ROW_PIX; k++) row[8*k +: 8] = 8'(8 * base + 24 * r + k);
        return row;
    endfunction

    // Row monitor: pops the scoreboard on every row pulse.
    always @(negedge clk) begin
        if (bus.row_valid_o) begin
            if (exp_q.size() > 0) begin
                exp_mon = exp_q.pop_front();
                check_eq("row_data", bus.row_o, exp_mon);
            end else begin
                check_eq("row_unexpected", ROW_W'(bus.row_valid_o), ROW_W'(0));
            end
            if (spacing_on && rows_in_window > 0)
                check_eq("row_spacing", ROW_W'(cyc - last_rv_cyc), ROW_W'(3));
            rows_in_window++;
            if (rows_in_window == ROWS)
                check_eq("busy_last_row", ROW_W'(bus.busy_o), ROW_W'(1));
            last_rv_cyc = cyc;
            $display("row %0d at cycle %0d: %h", rows_in_window - 1, cyc, bus.row_o);
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_row", bus.row_o, '0);
        check_eq("rst_row_valid", ROW_W'(bus.row_valid_o), ROW_W'(0));
        check_eq("rst_done", ROW_W'(bus.done_o), ROW_W'(0));
        check_eq("rst_busy", ROW_W'(bus.busy_o), ROW_W'(0));
        check_eq("rst_ready", ROW_W'(bus.in_ready_o), ROW_W'(0));
        rst_n = 1'b1;
        $display("reset applied at cycle %0d", cyc);
    endtask

    task automatic do_start();
        @(posedge clk);
        #1 bus.start_i = 1'b1;
        @(posedge clk);
        #1 bus.start_i = 1'b0;
        check_eq("start_ready", ROW_W'(bus.in_ready_o), ROW_W'(1));
        $display("start at cycle %0d", cyc);
    endtask

    // Feeds stop_after words (full window if negative); pulses start_i at word pulse_at.
    task automatic send_window(input int base, input bit gaps, input int pulse_at, input int stop_after);
        int n = 0;
        int budget = 0;
        bit pulsed = 1'b0;
        int nwords = (stop_after < 0) ? 3 * ROWS : stop_after;
        spacing_on = !gaps;
        rows_in_window = 0;
        do_start();
        while (n < nwords && budget < 4000) begin
            bus.in_valid_i = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.in_data_i  = make_word(base + n);
            bus.start_i    = 1'b0;
            if (!pulsed && pulse_at >= 0 && n == pulse_at) begin
                bus.start_i = 1'b1;
                pulsed = 1'b1;
            end
            check_eq("busy_fill", ROW_W'(bus.busy_o), ROW_W'(1));
            if (bus.in_valid_i && bus.in_ready_o) begin
                if (n % 3 == 2) exp_q.push_back(make_row(base, n / 3));
                n++;
            end
            @(posedge clk);
            #1;
            budget++;
        end
        bus.in_valid_i = 1'b0;
        bus.start_i    = 1'b0;
        check_eq("send_budget", ROW_W'(n), ROW_W'(nwords));
        $display("sent %0d words base %0d gaps %0d", n, base, gaps);
    endtask

    task automatic wait_done();
        int k = 0;
        bit seen = 1'b0;
        while (!seen && k < 20) begin
            @(negedge clk);
            if (bus.done_o) seen = 1'b1;
            else k++;
        end
        check_eq("done_seen", ROW_W'(seen), ROW_W'(1));
        if (seen) begin
            check_eq("done_latency", ROW_W'(cyc - last_rv_cyc), ROW_W'(1));
            check_eq("row_count", ROW_W'(rows_in_window), ROW_W'(ROWS));
            check_eq("queue_empty", ROW_W'(exp_q.size()), ROW_W'(0));
            check_eq("busy_after_done", ROW_W'(bus.busy_o), ROW_W'(0));
        end
        $display("done at cycle %0d, rows %0d", cyc, rows_in_window);
    endtask

    initial begin
        bus.start_i    = 1'b0;
        bus.in_data_i  = '0;
        bus.in_valid_i = 1'b0;
        do_reset();

        // Words offered in IDLE must be refused.
        bus.in_valid_i = 1'b1;
        bus.in_data_i  = make_word(0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check_eq("idle_ready", ROW_W'(bus.in_ready_o), ROW_W'(0));
            check_eq("idle_row_valid", ROW_W'(bus.row_valid_o), ROW_W'(0));
        end
        bus.in_valid_i = 1'b0;
`ifdef REF_PACK_ERR_EN
        check_eq("err_idle_valid", ROW_W'(bus.err_o), ROW_W'(1));
`endif
        do_reset();
`ifdef REF_PACK_ERR_EN
        check_eq("err_cleared", ROW_W'(bus.err_o), ROW_W'(0));
`endif

        send_window(0, 1'b0, -1, -1);
        wait_done();
        send_window(100, 1'b1, -1, -1);
        wait_done();

        // Reset after two words of row 5, then a fresh window.
        send_window(0, 1'b0, -1, 17);
        check_eq("mid_rows_seen", ROW_W'(rows_in_window), ROW_W'(5));
        do_reset();
        send_window(200, 1'b0, -1, -1);
        wait_done();

        // Stray start at row 10 must not disturb the window.
        send_window(300, 1'b0, 30, -1);
        wait_done();
`ifdef REF_PACK_ERR_EN
        check_eq("err_start_fill", ROW_W'(bus.err_o), ROW_W'(1));
        do_reset();
`endif

        // Back-to-back windows: start issued the cycle after done_o.
        send_window(7, 1'b0, -1, -1);
        wait_done();
        send_window(50, 1'b1, -1, -1);
        wait_done();

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
